// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on load-use or flush,
// global hold, and a saturating count of inserted load-use bubbles.
module id_ex_hazard_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             id_mem_to_reg_i,
  input  logic             id_alu_src_i,
  input  logic [1:0]       id_alu_op_i,
  input  logic [9:0]       id_funct_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic             flush_i,
  input  logic             hold_i,

  output logic             ex_valid_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic             ex_uses_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_mem_to_reg_o,
  output logic             ex_alu_src_o,
  output logic [1:0]       ex_alu_op_o,
  output logic [9:0]       ex_funct_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            uses_rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [9:0]      funct;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } stage_t;

  stage_t            ex_q, ex_d;
  stage_t            id_stage;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              rd_match;
  logic              load_use;
  logic              front_write;

  // Invalid ID slots enter EX with all control cleared so nothing downstream can write.
  always_comb begin
    id_stage          = '0;
    id_stage.valid    = id_valid_i;
    id_stage.rs1      = id_rs1_i;
    id_stage.rs2      = id_rs2_i;
    id_stage.uses_rs2 = id_uses_rs2_i;
    id_stage.rd       = id_rd_i;
    id_stage.funct    = id_funct_i;
    id_stage.rs1_data = id_rs1_data_i;
    id_stage.rs2_data = id_rs2_data_i;
    id_stage.imm      = id_imm_i;
    id_stage.pc       = id_pc_i;
    if (id_valid_i) begin
      id_stage.reg_write  = id_reg_write_i;
      id_stage.mem_read   = id_mem_read_i;
      id_stage.mem_write  = id_mem_write_i;
      id_stage.mem_to_reg = id_mem_to_reg_i;
      id_stage.alu_src    = id_alu_src_i;
      id_stage.alu_op     = id_alu_op_i;
    end
  end

  // Stores read Rs2 too, so they stall on a pending load since there is no MEM->MEM forward.
  always_comb begin
    rd_match = (ex_q.rd == id_rs1_i) || (id_uses_rs2_i && (ex_q.rd == id_rs2_i));
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid_i && rd_match;
  end

  // Reset forces the front end open regardless of hold.
  assign front_write   = rst || (!(load_use && !flush_i) && !hold_i);
  assign pc_write_o    = front_write;
  assign if_id_write_o = front_write;

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (hold_i) begin
      ex_d        = ex_q;
      stall_cnt_d = stall_cnt_q;
    end else if (flush_i) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      ex_d = id_stage;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_rs1_o        = ex_q.rs1;
  assign ex_rs2_o        = ex_q.rs2;
  assign ex_uses_rs2_o   = ex_q.uses_rs2;
  assign ex_rd_o         = ex_q.rd;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_funct_o      = ex_q.funct;
  assign ex_rs1_data_o   = ex_q.rs1_data;
  assign ex_rs2_data_o   = ex_q.rs2_data;
  assign ex_imm_o        = ex_q.imm;
  assign ex_pc_o         = ex_q.pc;
  assign stall_count_o   = stall_cnt_q;

endmodule
